// File: rtl/pipearch_common.sv
// -----------------------------------------------------------------------------
// pipearch_common
//   Shared definitions for the pipeline architecture blocks.
//   - LINE_W_DEFAULT / ADDR_W_DEFAULT : default data line and line address widths
//   - t_drainstate                    : state encoding of the memory write drain
//
//   Build option: MEM_WRITE_DRAIN_RESP_WAIT_EN adds the WAIT_RESP state, used
//   when the drain waits for write completions before finishing.
// -----------------------------------------------------------------------------
package pipearch_common;

    localparam int LINE_W_DEFAULT = 512;
    localparam int ADDR_W_DEFAULT = 42;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
        WAIT_RESP = 2'd2,
`endif
        DONE      = 2'd3
    } t_drainstate;

endpackage

// File: rtl/mem_write_drain.sv
// -----------------------------------------------------------------------------
// mem_write_drain
//   Drains a programmed number of lines from a FIFO into consecutive memory
//   line addresses, then pulses op_done.
//
//   Build option: MEM_WRITE_DRAIN_RESP_WAIT_EN
//     defined   : the operation completes only after one wr_resp_valid has been
//                 seen per issued line (WAIT_RESP state + acked counter).
//     undefined : the operation completes right after the last request is
//                 issued; wr_resp_valid is ignored.
//
//   Ports
//     clk, reset     : clock, synchronous active-high reset
//     op_start       : one-cycle start, honoured only in IDLE
//     configreg      : [31:16] line count, [15:0] reserved
//     base_addr      : line address of the first write, sampled on op_start
//     fifo_empty     : FIFO holds no lines
//     fifo_re        : pop one line (combinational)
//     fifo_rdata     : popped line, valid one cycle after fifo_re
//     wr_valid       : memory write request strobe
//     wr_addr        : request line address
//     wr_data        : request data
//     wr_almostfull  : memory back-pressure (>= 2 free slots while low)
//     wr_resp_valid  : one write completion per asserted cycle
//     busy           : operation in progress
//     op_done        : one-cycle completion pulse
//     dbg_state_o    : current FSM state encoding, for observation only
//
//   Handshake: a pop happens in every cycle fifo_re is high; the popped line is
//   presented on wr_* in the next cycle with wr_valid high. The memory side has
//   no ready: wr_almostfull low guarantees room for the request already in
//   flight plus the one being popped, so a request is never refused.
// -----------------------------------------------------------------------------
module mem_write_drain
    import pipearch_common::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic [31:0]       configreg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic [LINE_W-1:0] fifo_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LINE_W-1:0] wr_data,
    input  logic              wr_almostfull,
    input  logic              wr_resp_valid,
    output logic              busy,
    output logic              op_done,
    output logic [1:0]        dbg_state_o
);

    t_drainstate       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       issued_q, issued_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
    logic [15:0]       acked_q, acked_d;
`else
    logic              resp_unused;
    assign resp_unused = wr_resp_valid;
`endif

    logic cfg_unused;
    assign cfg_unused = ^configreg[15:0];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_d     = base_q;
        issued_d   = issued_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        fifo_re    = 1'b0;
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
        acked_d    = acked_q;
        // Completions count in every active state, so a response landing in
        // the same cycle as the last request is never lost.
        if (state_q != IDLE && wr_resp_valid) begin
            acked_d = acked_q + 16'd1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    len_d    = configreg[31:16];
                    base_d   = base_addr;
                    issued_d = 16'd0;
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
                    acked_d  = 16'd0;
`endif
                    state_d  = (configreg[31:16] == 16'd0) ? DONE : ISSUE;
                end
            end

            ISSUE: begin
                // issued never passes len, so equality is the "all popped"
                // test; the exit is taken one cycle after the final pop.
                if (issued_q == len_q) begin
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
                    state_d = (acked_d == len_q) ? DONE : WAIT_RESP;
`else
                    state_d = DONE;
`endif
                end else if (!fifo_empty && !wr_almostfull) begin
                    fifo_re    = 1'b1;
                    issued_d   = issued_q + 16'd1;
                    wr_valid_d = 1'b1;
                    // Address wraps naturally at 2^ADDR_W.
                    wr_addr_d  = base_q + ADDR_W'(issued_q);
                end
            end

`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
            WAIT_RESP: begin
                if (acked_d == len_q) begin
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Address carries no reset; it is only meaningful with wr_valid.
        wr_addr_q <= wr_addr_d;
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= 16'd0;
            base_q     <= '0;
            issued_q   <= 16'd0;
            wr_valid_q <= 1'b0;
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
            acked_q    <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            wr_valid_q <= wr_valid_d;
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
            acked_q    <= acked_d;
`endif
        end
    end

    // The FIFO presents popped data exactly one cycle after fifo_re, which is
    // the cycle wr_valid is high, so the data path needs no register here.
    assign wr_data     = fifo_rdata;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign busy        = (state_q != IDLE);
    assign op_done     = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_write_drain.sv
// -----------------------------------------------------------------------------
// tb_mem_write_drain
//   Directed bench for mem_write_drain. Follows MEM_WRITE_DRAIN_RESP_WAIT_EN
//   so the same file serves both builds.
// -----------------------------------------------------------------------------
module tb_mem_write_drain;

    localparam int LINE_W = 512;
    localparam int ADDR_W = 42;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              op_start;
    logic [31:0]       configreg;
    logic [ADDR_W-1:0] base_addr;
    logic              fifo_empty;
    logic              fifo_re;
    logic [LINE_W-1:0] fifo_rdata;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [LINE_W-1:0] wr_data;
    logic              wr_almostfull;
    logic              wr_resp_valid;
    logic              busy;
    logic              op_done;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_write_drain #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_start      (op_start),
        .configreg     (configreg),
        .base_addr     (base_addr),
        .fifo_empty    (fifo_empty),
        .fifo_re       (fifo_re),
        .fifo_rdata    (fifo_rdata),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_almostfull (wr_almostfull),
        .wr_resp_valid (wr_resp_valid),
        .busy          (busy),
        .op_done       (op_done),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- FIFO model ----------------
    // Line k popped over the whole run carries mk_line(k); the FIFO is
    // non-empty while fewer than fifo_limit lines have been popped.
    function automatic logic [LINE_W-1:0] mk_line(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(k);
        return {16{w}};
    endfunction

    int fifo_pops  = 0;
    int fifo_limit = 0;
    assign fifo_empty = (fifo_pops >= fifo_limit);

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_rdata <= mk_line(fifo_pops);
            fifo_pops  <= fifo_pops + 1;
        end
    end

    // ---------------- memory response model ----------------
    // Each request is acknowledged two cycles later when resp_en is set;
    // resp_man lets the driver force responses directly.
    logic [1:0] resp_sr = 2'b00;
    logic       resp_en;
    logic       resp_man;
    always @(posedge clk) resp_sr <= {resp_sr[0], wr_valid};
    assign wr_resp_valid = (resp_en & resp_sr[1]) | resp_man;

    // ---------------- scoreboard / monitor ----------------
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] got_addr_q[$];
    logic [LINE_W-1:0] got_data_q[$];
    int                got_cyc_q[$];
    int done_cnt      = 0;
    int done_cyc      = -1;
    int last_resp_cyc = -1;
    int bad_re        = 0;

    always @(negedge clk) begin
        if (wr_valid) begin
            got_addr_q.push_back(wr_addr);
            got_data_q.push_back(wr_data);
            got_cyc_q.push_back(cyc);
        end
        if (op_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (wr_resp_valid) last_resp_cyc = cyc;
        if (fifo_re && (wr_almostfull || fifo_empty)) bad_re = bad_re + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_addr_q.delete();
        got_data_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic start_op(input logic [15:0] len, input logic [ADDR_W-1:0] base, output int s);
        op_start  = 1'b1;
        configreg = {len, 16'hBEEF};
        base_addr = base;
        s         = cyc;
        step(1);
        op_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == d0; i++) step(1);
        check_eq({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    // Compares captured writes with exp_q; data is expected in pop order
    // starting from line first_pop.
    task automatic expect_writes(input string tag, input int first_pop);
        int i;
        check_eq({tag, "_count"}, 64'(got_addr_q.size()), 64'(exp_q.size()));
        i = 0;
        while (exp_q.size() > 0 && got_addr_q.size() > 0) begin
            check_eq({tag, "_addr"}, 64'(got_addr_q.pop_front()), 64'(exp_q.pop_front()));
            check_eq({tag, "_data"}, 64'(got_data_q.pop_front() == mk_line(first_pop + i)), 64'd1);
            i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s, p0, d0, last_wr, bad0, r;
        reset         = 1'b1;
        op_start      = 1'b0;
        configreg     = 32'd0;
        base_addr     = '0;
        wr_almostfull = 1'b0;
        resp_en       = 1'b1;
        resp_man      = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check_eq("rst_fifo_re",  64'(fifo_re),   64'd0);
        check_eq("rst_wr_valid", 64'(wr_valid),  64'd0);
        check_eq("rst_busy",     64'(busy),      64'd0);
        check_eq("rst_op_done",  64'(op_done),   64'd0);
        check_eq("rst_state",    64'(dbg_state), 64'd0);

        // Stray responses in IDLE must not start or finish anything
        d0 = done_cnt;
        resp_man = 1'b1;
        step(3);
        resp_man = 1'b0;
        check_eq("stray_busy", 64'(busy), 64'd0);
        step(2);
        check_eq("stray_done", 64'(done_cnt - d0), 64'd0);

        // T1: len=4 base=0x100, FIFO pre-filled, no back-pressure
        clear_sb();
        p0 = fifo_pops;
        fifo_limit = fifo_pops + 4;
        d0 = done_cnt;
        start_op(16'd4, 42'h100, s);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 60);
        check_eq("t1_nwr", 64'(got_cyc_q.size()), 64'd4);
        if (got_cyc_q.size() == 4) begin
            check_eq("t1_first_lat", 64'(got_cyc_q[0]), 64'(s + 2));
            for (int i = 0; i < 3; i++)
                check_eq("t1_b2b", 64'(got_cyc_q[i+1] - got_cyc_q[i]), 64'd1);
            last_wr = got_cyc_q[3];
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
            check_eq("t1_done_cyc", 64'(done_cyc), 64'(last_resp_cyc + 1));
`else
            check_eq("t1_done_cyc", 64'(done_cyc), 64'(last_wr + 1));
`endif
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(42'h100 + 42'(i));
        expect_writes("t1", p0);
        step(3);
        check_eq("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check_eq("t1_idle_busy", 64'(busy), 64'd0);

        // T2: len=0 -> no pops, no writes, op_done the cycle after op_start
        clear_sb();
        p0 = fifo_pops;
        fifo_limit = fifo_pops + 2;
        start_op(16'd0, 42'h300, s);
        wait_done("t2", 10);
        check_eq("t2_done_cyc", 64'(done_cyc), 64'(s + 1));
        check_eq("t2_pops", 64'(fifo_pops - p0), 64'd0);
        check_eq("t2_nwr", 64'(got_addr_q.size()), 64'd0);
        step(2);

        // T3: len=8, wr_almostfull high on cycles 3..5 after op_start
        clear_sb();
        p0 = fifo_pops;
        fifo_limit = fifo_pops + 8;
        bad0 = bad_re;
        start_op(16'd8, 42'h1000, s);
        step(2);
        wr_almostfull = 1'b1;
        step(3);
        wr_almostfull = 1'b0;
        wait_done("t3", 60);
        check_eq("t3_no_pop_af", 64'(bad_re - bad0), 64'd0);
        if (got_cyc_q.size() == 8) begin
            check_eq("t3_wr2_cyc", 64'(got_cyc_q[2]), 64'(s + 7));
            check_eq("t3_wr7_cyc", 64'(got_cyc_q[7]), 64'(s + 12));
        end
        check_eq("t3_pops", 64'(fifo_pops - p0), 64'd8);
        for (int i = 0; i < 8; i++) exp_q.push_back(42'h1000 + 42'(i));
        expect_writes("t3", p0);
        step(2);

        // T4: address wrap at 2^ADDR_W
        clear_sb();
        p0 = fifo_pops;
        fifo_limit = fifo_pops + 4;
        start_op(16'd4, 42'h3FF_FFFF_FFFE, s);
        wait_done("t4", 60);
        exp_q.push_back(42'h3FF_FFFF_FFFE);
        exp_q.push_back(42'h3FF_FFFF_FFFF);
        exp_q.push_back(42'h000_0000_0000);
        exp_q.push_back(42'h000_0000_0001);
        expect_writes("t4", p0);
        step(2);

        // T5: second op_start while busy is ignored; reset on the 3rd write
        clear_sb();
        p0 = fifo_pops;
        fifo_limit = fifo_pops + 6;
        d0 = done_cnt;
        start_op(16'd6, 42'h200, s);
        op_start  = 1'b1;
        configreg = {16'd2, 16'h0000};
        base_addr = 42'h999;
        step(1);
        op_start  = 1'b0;
        step(2);
        check_eq("t5_wr3_valid", 64'(wr_valid), 64'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("t5_fifo_re", 64'(fifo_re),  64'd0);
        check_eq("t5_wr_valid", 64'(wr_valid), 64'd0);
        check_eq("t5_busy",    64'(busy),     64'd0);
        check_eq("t5_op_done", 64'(op_done),  64'd0);
        step(15);
        check_eq("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("t5_idle",    64'(busy),          64'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(42'h200 + 42'(i));
        expect_writes("t5", p0);

        // T6: len=2 completion behaviour against wr_resp_valid
        clear_sb();
        p0 = fifo_pops;
        fifo_limit = fifo_pops + 2;
        d0 = done_cnt;
`ifdef MEM_WRITE_DRAIN_RESP_WAIT_EN
        resp_en = 1'b0;
        start_op(16'd2, 42'h40, s);
        step(12);
        check_eq("t6_wait_busy", 64'(busy), 64'd1);
        check_eq("t6_no_done",   64'(done_cnt - d0), 64'd0);
        r = cyc;
        resp_man = 1'b1;
        step(2);
        resp_man = 1'b0;
        wait_done("t6", 10);
        check_eq("t6_done_cyc", 64'(done_cyc), 64'(r + 2));
        resp_en = 1'b1;
`else
        resp_man = 1'b1;
        start_op(16'd2, 42'h40, s);
        wait_done("t6", 20);
        resp_man = 1'b0;
        r = 0;
        if (got_cyc_q.size() == 2)
            check_eq("t6_done_cyc", 64'(done_cyc), 64'(got_cyc_q[1] + 1));
`endif
        exp_q.push_back(42'h40);
        exp_q.push_back(42'h41);
        expect_writes("t6", p0);
        step(3);
        check_eq("t6_done_once", 64'(done_cnt - d0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
